// File: rtl/neuron_mac_sequencer.sv
// Hidden-layer neuron dot-product sequencer for the ELM datapath.
// Streams LEN x/w pairs through the shift-add multiplier's start/done
// handshake, accumulates the products and offers the sum on a valid/ready port.
// Build option: define NEURON_MAC_SAT_EN to saturate out_data to all-ones when
// out_ovf is set; otherwise out_data is the truncated accumulator.
module neuron_mac_sequencer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_x,
    input  logic [DATA_W-1:0]   in_w,
    output logic                mul_start,
    output logic [DATA_W-1:0]   mul_a,
    output logic [DATA_W-1:0]   mul_b,
    input  logic                mul_done,
    input  logic [2*DATA_W-1:0] mul_product,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_ovf,
    output logic                busy
);

    localparam int unsigned ACC_XW = ACC_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MUL   = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   mul_a_q, mul_a_d;
    logic [DATA_W-1:0]   mul_b_q, mul_b_d;
    logic                in_ready_q, in_ready_d;
    logic                mul_start_q, mul_start_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic                out_ovf_q, out_ovf_d;
    logic                busy_q, busy_d;
    logic [ACC_W:0]      sum_ext;
    logic                ovf_full;

    // Next-state, datapath update and registered-output decode
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        sum_ext     = {1'b0, acc_q} + ACC_XW'(mul_product);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? S_OUT : S_FETCH;
                end
            end
            S_FETCH: begin
                if (in_valid && in_ready_q) begin
                    mul_a_d = in_x;
                    mul_b_d = in_w;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    acc_d   = sum_ext[ACC_W-1:0];
                    ovf_d   = ovf_q | sum_ext[ACC_W];
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_q == len_q - LEN_W'(1)) ? S_OUT : S_FETCH;
                end
            end
            S_OUT: begin
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output flops track the state being entered, except out_valid which
        // rises one cycle into OUT and drops on the accepting edge.
        in_ready_d  = (state_d == S_FETCH);
        mul_start_d = (state_d == S_MUL);
        busy_d      = (state_d != S_IDLE);
        out_valid_d = (state_q == S_OUT) && !(out_valid_q && out_ready);

        ovf_full    = ovf_d | (|acc_d[ACC_W-1:OUT_W]);
        out_ovf_d   = (state_d == S_OUT) ? ovf_full : 1'b0;
`ifdef NEURON_MAC_SAT_EN
        out_data_d  = (state_d != S_OUT) ? '0 :
                      (ovf_full ? {OUT_W{1'b1}} : acc_d[OUT_W-1:0]);
`else
        out_data_d  = (state_d == S_OUT) ? acc_d[OUT_W-1:0] : '0;
`endif
    end

    // State and output registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            in_ready_q  <= 1'b0;
            mul_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            in_ready_q  <= in_ready_d;
            mul_start_q <= mul_start_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer with a behavioural 18-cycle multiplier.
module tb_neuron_mac_sequencer;

    localparam int LAT = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int n_mstart = 0;
    int ir_bad = 0;
    int cd = 0;
    logic [31:0] prod = '0;
    logic spur_done = 1'b0;

    neuron_mac_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: done pulse LAT cycles after start, plus injected strays
    always @(negedge clk) begin
        if (mul_start) n_mstart++;
        if (in_ready && (mul_start || out_valid || !busy)) ir_bad++;
        mul_done = spur_done;
        if (spur_done) mul_product = 32'hDEAD_BEEF;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mul_done    = 1'b1;
                mul_product = prod;
            end
        end
        if (mul_start) begin
            cd   = LAT;
            prod = {16'h0, mul_a} * {16'h0, mul_b};
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] x, input logic [15:0] w, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        in_x = x;
        in_w = w;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int t;
        t = 0;
        while (!out_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic finish_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int base;
        int stab_bad;
        logic [31:0] exp_ff;
        int gaps[5];
        gaps = '{3, 0, 5, 1, 2};

        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_x = '0; in_w = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // len=3 basic dot product
        base = n_mstart;
        do_start(8'd3);
        chk("t1_busy", 64'(busy), 64'd1);
        send_pair(16'd2, 16'd3, 0);
        send_pair(16'd4, 16'd5, 0);
        send_pair(16'd100, 16'd200, 0);
        wait_out("t1_out_valid");
        chk("t1_data", 64'(out_data), 64'd20026);
        chk("t1_ovf", 64'(out_ovf), 64'd0);
        chk("t1_mul_starts", 64'(n_mstart - base), 64'd3);
        finish_out("t1");

        // len=0: OUT reached without FETCH, out_valid two cycles after start
        base = n_mstart;
        do_start(8'd0);
        chk("t2_valid_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_data", 64'(out_data), 64'd0);
        chk("t2_ovf", 64'(out_ovf), 64'd0);
        finish_out("t2");
        chk("t2_mul_starts", 64'(n_mstart - base), 64'd0);

        // len=2 of 0xFFFF^2: sum 0x1_FFFC_0002 overflows 32 bits
`ifdef NEURON_MAC_SAT_EN
        exp_ff = 32'hFFFF_FFFF;
`else
        exp_ff = 32'hFFFC_0002;
`endif
        do_start(8'd2);
        send_pair(16'hFFFF, 16'hFFFF, 0);
        send_pair(16'hFFFF, 16'hFFFF, 0);
        wait_out("t3_out_valid");
        chk("t3_data", 64'(out_data), 64'(exp_ff));
        chk("t3_ovf", 64'(out_ovf), 64'd1);
        finish_out("t3");

        // Backpressure in OUT with stray start and mul_done pulses
        base = n_mstart;
        do_start(8'd1);
        send_pair(16'd3, 16'd5, 0);
        wait_out("t4_out_valid");
        stab_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || out_data != 32'd15 || out_ovf || mul_start) stab_bad++;
            start     = (i % 2 == 0);
            len       = 8'd0;
            spur_done = (i % 2 == 1);
            @(negedge clk);
        end
        spur_done = 1'b0;
        chk("t4_stable", 64'(stab_bad), 64'd0);
        chk("t4_data", 64'(out_data), 64'd15);
        start = 1'b1;
        finish_out("t4");
        start = 1'b0;
        @(negedge clk);
        chk("t4_still_idle", 64'(busy), 64'd0);
        chk("t4_mul_starts", 64'(n_mstart - base), 64'd1);

        // Reset while waiting on element 2 of len=4; late done must be ignored
        do_start(8'd4);
        send_pair(16'd1, 16'd1, 0);
        send_pair(16'd2, 16'd2, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_mul_a", 64'(mul_a), 64'd0);
        chk("t5_mul_b", 64'(mul_b), 64'd0);
        chk("t5_out", 64'({out_valid, out_ovf, out_data}), 64'd0);
        repeat (25) @(negedge clk);
        chk("t5_late_done", 64'({busy, out_valid, in_ready}), 64'd0);
        do_start(8'd1);
        send_pair(16'd7, 16'd6, 0);
        wait_out("t5_out_valid");
        chk("t5_data", 64'(out_data), 64'd42);
        finish_out("t5");

        // len=5 with input stalls, x=w=i+1
        base = n_mstart;
        ir_bad = 0;
        do_start(8'd5);
        for (int i = 0; i < 5; i++) send_pair(16'(i + 1), 16'(i + 1), gaps[i]);
        wait_out("t6_out_valid");
        chk("t6_data", 64'(out_data), 64'd55);
        chk("t6_mul_starts", 64'(n_mstart - base), 64'd5);
        finish_out("t6");
        chk("t6_in_ready_decode", 64'(ir_bad), 64'd0);

        // len=255 must not wrap the element counter
        base = n_mstart;
        do_start(8'd255);
        for (int i = 0; i < 255; i++) send_pair(16'd1, 16'd1, 0);
        wait_out("t7_out_valid");
        chk("t7_data", 64'(out_data), 64'd255);
        chk("t7_mul_starts", 64'(n_mstart - base), 64'd255);
        finish_out("t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/neuron_mac_sequencer.md
Name: neuron_mac_sequencer

Overview:
- Hidden-layer neuron dot-product engine for the ELM datapath. Sits directly upstream of the 16x16 shift-add multiplier (controller plus datapath).
- Streams LEN input/weight pairs, issues one multiply per pair through the multiplier's start/done handshake, and accumulates the 32-bit products.
- Presents the neuron pre-activation sum downstream on a valid/ready port.

Parameters:
- DATA_W, 16, width of x and w operands and of each multiplier operand.
- ACC_W, 40, accumulator width.
- OUT_W, 32, output sum width.
- LEN_W, 8, width of the vector-length input.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a dot product; sampled only in IDLE
- len  in  LEN_W  number of pairs; latched on accepted start
- in_valid  in  1  x/w pair valid
- in_ready  out  1  sequencer accepts pair
- in_x  in  DATA_W  input feature, unsigned
- in_w  in  DATA_W  weight, unsigned
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_a  out  DATA_W  multiplicand, registered
- mul_b  out  DATA_W  multiplier, registered
- mul_done  in  1  one-cycle pulse, product valid
- mul_product  in  2*DATA_W  product
- out_valid  out  1  sum valid
- out_ready  in  1  downstream accepts sum
- out_data  out  OUT_W  dot-product result
- out_ovf  out  1  result exceeded OUT_W (or accumulator wrapped)
- busy  out  1  high in any state but IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, acc=0, cnt=0, ovf sticky=0. A reset mid-operation abandons the operation immediately, with no output and no mul_start. A mul_done arriving after reset, while in IDLE, is ignored.
- States and transitions:
  - IDLE: start=1 latches len, clears acc/cnt/ovf. If len==0, go to OUT with sum 0; otherwise go to FETCH. start is ignored in every other state.
  - FETCH: in_ready=1. On in_valid&in_ready, register mul_a=in_x and mul_b=in_w, then go to MUL.
  - MUL: mul_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold mul_a/mul_b stable. On mul_done:
    - acc <= acc + zero-extended mul_product, modulo 2^ACC_W; a carry-out sets sticky ovf.
    - cnt <= cnt+1.
    - If cnt==len-1, go to OUT; otherwise go to FETCH.
  - OUT: out_valid=1. out_data and out_ovf are held stable until out_valid&out_ready, then go to IDLE the next cycle. out_valid stays high until accepted.
- Timing:
  - in_ready and out_valid are registered state decodes. No combinational path from in_valid to in_ready, or from out_ready to out_valid.
  - Per-element latency: accept (1) + MUL (1) + multiplier latency (start to done, 18 cycles with the 16-bit shift-add unit) + accumulate, which completes on the done edge.
  - Next FETCH begins the cycle after mul_done.
- Width and overflow:
  - out_data = acc[OUT_W-1:0].
  - out_ovf = sticky ovf OR (acc[ACC_W-1:OUT_W] != 0).
- Boundary cases:
  - mul_done in any state other than WAIT is ignored.
  - len=1 produces exactly one multiply.
  - len=2^LEN_W-1 must not wrap cnt.
  - in_valid held high in WAIT or MUL is not consumed.
  - start together with out_ready in OUT is ignored; a new start is accepted only once back in IDLE.

Optional Feature:
- Macro: NEURON_MAC_SAT_EN.
- With the macro defined: when out_ovf=1, out_data = {OUT_W{1'b1}} (saturate to max). out_ovf still reports the event.
- Without the macro: out_data is plain truncation acc[OUT_W-1:0], and out_ovf is still reported.

Test Plan:
- len=3, pairs (2,3),(4,5),(100,200): exactly 3 mul_start pulses; out_data=20026; out_ovf=0; busy falls after the out handshake.
- len=0 start: out_valid=1 two cycles after start (FETCH skipped) with out_data=0; no mul_start ever asserted.
- len=2, pairs (0xFFFF,0xFFFF) twice:
  - sum=0x1_FFFC_0002, so out_ovf=1.
  - Without the macro: out_data=0xFFFC0002.
  - With NEURON_MAC_SAT_EN: out_data=0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid/out_data stable; pulses of start and spurious mul_done are ignored; the release completes the handshake in 1 cycle.
- Assert rst in WAIT of element 2 of len=4 -> next cycle all outputs 0 and state IDLE; a late mul_done is ignored. A following len=1 (7,6) run returns out_data=42.
- in_valid stalls (random gaps 0-5 cycles) across len=5 with x=w=i+1 -> out_data=55; in_ready is asserted only in FETCH.
